// File: rtl/tinyml_skew_feeder_pkg.sv
// ============================================================================
// Module  : tinyml_pkg
// Brief   : Shared types and defaults for the TinyML skew feeder.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package tinyml_pkg;

  localparam int c_data_w    = 8;
  localparam int c_array_dim = 4;
  localparam int c_addr_w    = 16;
  localparam int c_dim_w     = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    FEED  = 2'd2,
    FIN   = 2'd3
  } state_t;

  // LSB position of a lane inside a packed multi-lane word.
  function automatic int lane_lo(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

`default_nettype wire

// File: rtl/tinyml_skew_feeder_lane_delay.sv
// ============================================================================
// Module  : tinyml_lane_delay
// Brief   : Enable-gated shift register carrying {valid, data}; DEPTH=0 is a wire.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tinyml_lane_delay #(
  parameter int DEPTH  = 1,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              en,
  input  logic [DATA_W:0]   d_in,
  output logic [DATA_W:0]   d_out
);

  generate
    if (DEPTH == 0) begin : g_wire
      logic w_unused;
      assign w_unused = &{1'b0, clk, reset, clr, en};
      assign d_out    = d_in;
    end else begin : g_shift
      logic [DATA_W:0] r_stage [DEPTH];

      always_ff @(posedge clk) begin
        if (reset || clr) begin
          for (int i = 0; i < DEPTH; i++) r_stage[i] <= '0;
        end else if (en) begin
          r_stage[0] <= d_in;
          for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
        end
      end

      assign d_out = r_stage[DEPTH-1];
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/tinyml_skew_feeder.sv
// ============================================================================
// Module  : tinyml_skew_feeder
// Brief   : Fetches an m-row tile from the unified buffer and feeds it to the
//           systolic array in skewed order, with backpressure.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tinyml_skew_feeder
  import tinyml_pkg::*;
#(
  parameter int DATA_W    = c_data_w,
  parameter int ARRAY_DIM = c_array_dim,
  parameter int ADDR_W    = c_addr_w,
  parameter int DIM_W     = c_dim_w
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [DIM_W-1:0]              m,
  input  logic [DIM_W-1:0]              n,
  input  logic [ADDR_W-1:0]             base_addr,
  output logic                          busy,
  output logic                          done,
  output logic                          cfg_err,
  output logic                          uni_ren,
  output logic [ADDR_W-1:0]             uni_addr,
  input  logic [ARRAY_DIM*DATA_W-1:0]   uni_data_in,
  output logic [ARRAY_DIM*DATA_W-1:0]   sa_data,
  output logic [ARRAY_DIM-1:0]          sa_valid,
  input  logic                          out_ready
);

  localparam logic [DIM_W:0] c_max_n = (DIM_W+1)'(ARRAY_DIM);

  state_t                        r_state;
  logic [DIM_W-1:0]              r_m;
  logic [DIM_W-1:0]              r_n;
  logic [DIM_W-1:0]              r_rows_read;
  logic [ADDR_W-1:0]             r_base;
  logic [DIM_W:0]                r_step;
  logic                          r_rd_pend;
  logic [ARRAY_DIM*DATA_W-1:0]   r_row_buf;

  logic [ARRAY_DIM*DATA_W-1:0]   w_row;
  logic [ARRAY_DIM*DATA_W-1:0]   w_shift_data;
  logic [ARRAY_DIM-1:0]          w_shift_valid;
  logic [DIM_W:0]                w_last_step;
  logic                          w_start_ok;
  logic                          w_advance;
  logic                          w_last;
  logic                          w_row_live;
  logic                          w_ren;

  assign w_start_ok  = (m != '0) && (n != '0) && ({1'b0, n} <= c_max_n);
  assign w_last_step = {1'b0, r_m} + {1'b0, r_n} - (DIM_W+1)'(1);

  // Step 0 is loaded unconditionally as soon as row 0 returns; later steps
  // load only when the currently presented step is accepted.
  assign w_advance  = (r_state == FEED) &&
                      ((r_step == '0) || (out_ready && (sa_valid != '0)));
  assign w_last     = w_advance && (r_step == w_last_step);
  assign w_row_live = r_step < {1'b0, r_m};

  // Read data is used straight off the bus when it lands on a loading cycle,
  // otherwise from the row buffer it was parked in during a stall.
  assign w_row = r_rd_pend ? uni_data_in : r_row_buf;

  // Each load prefetches the row needed by the next load.
  assign w_ren    = (r_state == FETCH) ||
                    (w_advance && !w_last && (r_rows_read < r_m));
  assign uni_ren  = w_ren;
  assign uni_addr = w_ren ? (r_base + ADDR_W'(r_rows_read)) : '0;

  generate
    for (genvar j = 0; j < ARRAY_DIM; j++) begin : g_lane
      localparam logic [DIM_W-1:0] c_lane = DIM_W'(j);
      logic [DATA_W:0] w_in;
      logic [DATA_W:0] w_out;

      assign w_in = (w_row_live && (c_lane < r_n)) ?
                    {1'b1, w_row[lane_lo(j, DATA_W) +: DATA_W]} : '0;

      tinyml_lane_delay #(
        .DEPTH  (j),
        .DATA_W (DATA_W)
      ) u_delay (
        .clk   (clk),
        .reset (reset),
        .clr   (w_last),
        .en    (w_advance),
        .d_in  (w_in),
        .d_out (w_out)
      );

      assign w_shift_data[lane_lo(j, DATA_W) +: DATA_W] = w_out[DATA_W-1:0];
      assign w_shift_valid[j]                           = w_out[DATA_W];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      cfg_err     <= 1'b0;
      sa_data     <= '0;
      sa_valid    <= '0;
      r_m         <= '0;
      r_n         <= '0;
      r_rows_read <= '0;
      r_base      <= '0;
      r_step      <= '0;
      r_rd_pend   <= 1'b0;
      r_row_buf   <= '0;
    end else begin
      done      <= 1'b0;
      cfg_err   <= 1'b0;
      r_rd_pend <= w_ren;
      if (r_rd_pend) r_row_buf <= uni_data_in;
      if (w_ren) r_rows_read <= r_rows_read + DIM_W'(1);

      if (w_advance) begin
        r_step   <= r_step + (DIM_W+1)'(1);
        sa_data  <= w_last ? '0 : w_shift_data;
        sa_valid <= w_last ? '0 : w_shift_valid;
      end

      case (r_state)
        IDLE: begin
          if (start) begin
            if (w_start_ok) begin
              r_m         <= m;
              r_n         <= n;
              r_base      <= base_addr;
              r_rows_read <= '0;
              r_step      <= '0;
              busy        <= 1'b1;
              r_state     <= FETCH;
            end else begin
              cfg_err <= 1'b1;
            end
          end
        end
        FETCH: r_state <= FEED;
        FEED: begin
          if (w_last) begin
            busy    <= 1'b0;
            done    <= 1'b1;
            r_state <= FIN;
          end
        end
        FIN:     r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_tinyml_skew_feeder.sv
// ============================================================================
// Module  : tb_tinyml_skew_feeder
// Brief   : Self-checking bench for tinyml_skew_feeder against a step model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tinyml_skew_feeder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        out_ready = 1'b1;
  logic [4:0]  m_i = '0;
  logic [4:0]  n_i = '0;
  logic [15:0] base_i = '0;
  logic        busy, done, cfg_err, uni_ren;
  logic [15:0] uni_addr;
  logic [31:0] uni_data_in;
  logic [31:0] sa_data;
  logic [3:0]  sa_valid;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem [65536];
  logic [15:0] reads [$];
  logic [31:0] obs_data  [64];
  logic [3:0]  obs_valid [64];
  logic [7:0]  a [32][4];

  tinyml_skew_feeder dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .m           (m_i),
    .n           (n_i),
    .base_addr   (base_i),
    .busy        (busy),
    .done        (done),
    .cfg_err     (cfg_err),
    .uni_ren     (uni_ren),
    .uni_addr    (uni_addr),
    .uni_data_in (uni_data_in),
    .sa_data     (sa_data),
    .sa_valid    (sa_valid),
    .out_ready   (out_ready)
  );

  always #5 clk = ~clk;

  // Buffer model: one-cycle read latency, garbage on idle cycles.
  always @(posedge clk) begin
    if (uni_ren) begin
      uni_data_in <= mem[uni_addr];
      reads.push_back(uni_addr);
    end else begin
      uni_data_in <= $urandom;
    end
  end

  function automatic void exp_step(input int k, input int mm, input int nn,
                                   output logic [31:0] d, output logic [3:0] v);
    d = '0;
    v = '0;
    for (int j = 0; j < 4; j++) begin
      if (j < nn && k - j >= 0 && k - j < mm) begin
        v[j]       = 1'b1;
        d[j*8 +: 8] = a[k-j][j];
      end
    end
  endfunction

  task automatic run_tile(input int mm, input int nn, input logic [15:0] bb,
                          input bit rnd_data, input int stall_at, input int stall_len,
                          input bit rnd_ready, input bit busy_starts, input int abort_idx);
    int idx, stalls, t_first, t_done;
    bit vis, rdy, fin;
    logic [31:0] ed;
    logic [3:0]  ev;
    for (int r = 0; r < mm; r++) begin
      for (int j = 0; j < 4; j++) a[r][j] = rnd_data ? 8'($urandom) : 8'(r*16 + j);
      mem[bb + 16'(r)] = {a[r][3], a[r][2], a[r][1], a[r][0]};
    end
    for (int i = 0; i < 64; i++) begin
      obs_data[i]  = '0;
      obs_valid[i] = '0;
    end
    idx = 0; stalls = 0; t_first = -1; t_done = -1; fin = 0;
    @(negedge clk);
    m_i = 5'(mm); n_i = 5'(nn); base_i = bb; start = 1'b1; out_ready = 1'b1;
    reads.delete();
    for (int t = 1; t <= 300 && !fin; t++) begin
      @(negedge clk);
      vis = (sa_valid != 4'b0);
      rdy = 1'b1;
      if (rnd_ready && vis) rdy = ($urandom_range(0, 3) != 0);
      if (vis && idx == stall_at && stalls < stall_len) rdy = 1'b0;
      start = busy_starts && (t == 2 || t == 5);
      if (start) begin m_i = 5'd1; n_i = 5'd1; base_i = 16'hFFF0; end
      out_ready = rdy;
      #1;
      if (vis && idx == abort_idx) return;
      if (t == 1) begin
        total++;
        if ({uni_ren, uni_addr} !== {1'b1, bb}) begin
          bad++; $display("FAIL first_read got=%b/%h exp=1/%h", uni_ren, uni_addr, bb);
        end
      end
      if (done) begin
        fin = 1; t_done = t;
        total++;
        if ({busy, cfg_err, sa_valid, sa_data} !== '0 || idx != mm + nn - 1) begin
          bad++; $display("FAIL done_state busy=%b v=%b d=%h steps=%0d exp steps=%0d",
                          busy, sa_valid, sa_data, idx, mm + nn - 1);
        end
        if (busy_starts) begin start = 1'b1; m_i = 5'd2; n_i = 5'd1; base_i = 16'hAAAA; end
      end else begin
        total++;
        if ({busy, cfg_err} !== 2'b10) begin
          bad++; $display("FAIL busy_flags t=%0d got busy=%b cfg_err=%b exp 1/0", t, busy, cfg_err);
        end
        if (vis) begin
          exp_step(idx, mm, nn, ed, ev);
          if (t_first < 0) t_first = t;
          if (idx < 64) begin obs_data[idx] = sa_data; obs_valid[idx] = sa_valid; end
          total++;
          if (sa_data !== ed || sa_valid !== ev) begin
            bad++; $display("FAIL step k=%0d got=%h/%b exp=%h/%b", idx, sa_data, sa_valid, ed, ev);
          end
          if (!rdy) begin
            stalls++;
            total++;
            if (uni_ren !== 1'b0) begin
              bad++; $display("FAIL stall_ren k=%0d got=%b exp=0", idx, uni_ren);
            end
          end else begin
            idx++;
          end
        end else begin
          total++;
          if (sa_data !== 32'h0) begin
            bad++; $display("FAIL idle_data t=%0d got=%h exp=0", t, sa_data);
          end
        end
      end
    end
    total++;
    if (!fin) begin
      bad++; $display("FAIL timeout m=%0d n=%0d got no done exp done", mm, nn);
    end else begin
      total++;
      if (t_first != 3) begin
        bad++; $display("FAIL latency got=%0d exp=3", t_first);
      end
      total++;
      if (t_done != mm + nn + 2 + stalls) begin
        bad++; $display("FAIL done_time got=%0d exp=%0d", t_done, mm + nn + 2 + stalls);
      end
      total++;
      if (reads.size() != mm) begin
        bad++; $display("FAIL read_count got=%0d exp=%0d", reads.size(), mm);
      end else begin
        for (int i = 0; i < mm; i++) begin
          total++;
          if (reads[i] !== bb + 16'(i)) begin
            bad++; $display("FAIL read_addr i=%0d got=%h exp=%h", i, reads[i], bb + 16'(i));
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    total++;
    if ({busy, done, cfg_err, uni_ren, uni_addr, sa_data, sa_valid} !== '0) begin
      bad++; $display("FAIL reset_outputs got busy=%b done=%b err=%b ren=%b d=%h v=%b exp all 0",
                      busy, done, cfg_err, uni_ren, sa_data, sa_valid);
    end
    reset = 1'b0;
  endtask

  task automatic test_basic_2x2();
    run_tile(2, 2, 16'h0010, 0, -1, 0, 0, 0, -1);
    total++;
    if (obs_data[0] !== 32'h00000000 || obs_valid[0] !== 4'b0001) begin
      bad++; $display("FAIL s1_step0 got=%h/%b exp=00000000/0001", obs_data[0], obs_valid[0]);
    end
    total++;
    if (obs_data[1] !== 32'h00000110 || obs_valid[1] !== 4'b0011) begin
      bad++; $display("FAIL s1_step1 got=%h/%b exp=00000110/0011", obs_data[1], obs_valid[1]);
    end
    total++;
    if (obs_data[2] !== 32'h00001100 || obs_valid[2] !== 4'b0010) begin
      bad++; $display("FAIL s1_step2 got=%h/%b exp=00001100/0010", obs_data[2], obs_valid[2]);
    end
  endtask

  task automatic test_full_4x4(input int stall_len);
    run_tile(4, 4, 16'h0020, 0, (stall_len > 0) ? 1 : -1, stall_len, 0, 0, -1);
    total++;
    if (obs_data[3] !== 32'h03122130 || obs_valid[3] !== 4'b1111) begin
      bad++; $display("FAIL s2_step3 got=%h/%b exp=03122130/1111", obs_data[3], obs_valid[3]);
    end
    total++;
    if (obs_data[6] !== 32'h33000000 || obs_valid[6] !== 4'b1000) begin
      bad++; $display("FAIL s2_step6 got=%h/%b exp=33000000/1000", obs_data[6], obs_valid[6]);
    end
  endtask

  task automatic test_cfg_err();
    int bm[3] = '{3, 0, 2};
    int bn[3] = '{5, 2, 0};
    reads.delete();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      m_i = 5'(bm[i]); n_i = 5'(bn[i]); base_i = 16'h1234; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      #1;
      total++;
      if ({cfg_err, busy, uni_ren} !== 3'b100) begin
        bad++; $display("FAIL cfg_err_pulse m=%0d n=%0d got err/busy/ren=%b%b%b exp=100",
                        bm[i], bn[i], cfg_err, busy, uni_ren);
      end
      @(negedge clk);
      #1;
      total++;
      if ({cfg_err, busy, uni_ren} !== 3'b000) begin
        bad++; $display("FAIL cfg_err_clear got err/busy/ren=%b%b%b exp=000", cfg_err, busy, uni_ren);
      end
    end
    total++;
    if (reads.size() != 0) begin
      bad++; $display("FAIL cfg_err_reads got=%0d exp=0", reads.size());
    end
    run_tile(2, 3, 16'h0070, 1, -1, 0, 0, 0, -1);
  endtask

  task automatic test_reset_mid();
    run_tile(4, 4, 16'h0040, 0, -1, 0, 0, 0, 2);
    reset = 1'b1;
    @(negedge clk);
    #1;
    total++;
    if ({busy, done, cfg_err, uni_ren, uni_addr, sa_data, sa_valid} !== '0) begin
      bad++; $display("FAIL reset_mid got busy=%b done=%b ren=%b d=%h v=%b exp all 0",
                      busy, done, uni_ren, sa_data, sa_valid);
    end
    reset = 1'b0;
    run_tile(1, 1, 16'h0080, 0, -1, 0, 0, 0, -1);
    total++;
    if (obs_data[0] !== 32'h0 || obs_valid[0] !== 4'b0001) begin
      bad++; $display("FAIL reset_mid_single got=%h/%b exp=00000000/0001", obs_data[0], obs_valid[0]);
    end
  endtask

  task automatic test_back_to_back();
    run_tile(3, 2, 16'h0050, 1, -1, 0, 0, 1, -1);
    run_tile(2, 4, 16'h0060, 1, -1, 0, 0, 0, -1);
  endtask

  task automatic test_random();
    int mm, nn;
    logic [15:0] bb;
    for (int it = 0; it < 8; it++) begin
      mm = (it == 7) ? 31 : $urandom_range(1, 12);
      nn = $urandom_range(1, 4);
      bb = (it == 3) ? 16'hFFFD : 16'($urandom);
      run_tile(mm, nn, bb, 1, -1, 0, 1, 0, -1);
    end
  endtask

  initial begin
    test_reset();
    test_basic_2x2();
    test_full_4x4(0);
    test_full_4x4(3);
    test_cfg_err();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=hang exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
